// File: rtl/ledmatrix_scan_if.sv
// ledmatrix_scan_if: frame buffer read port between the scan engine and the RAM.
// The scan engine issues rd_addr; the RAM returns rd_data one clock later.
interface ledmatrix_scan_if;
  logic [8:0]  rd_addr;
  logic [23:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/ledmatrix_scan.sv
// ledmatrix_scan: read-side scan engine for a 32x32 HUB75 panel.
// Shifts pixel pairs into the panel and drives row select, latch and output enable.
// Brightness comes from 4-plane binary code modulation.
// Optional feature: define LEDMATRIX_GAMMA_EN to pass each 4-bit colour field through
// a gamma-2.2 table before the bit plane is extracted.
module ledmatrix_scan #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned BASE_TICKS = 64,
  parameter int unsigned DEAD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  ledmatrix_scan_if.master fb,
  output logic             r1,
  output logic             g1,
  output logic             b1,
  output logic             r2,
  output logic             g2,
  output logic             b2,
  output logic             sclk,
  output logic             lat,
  output logic             oe_n,
  output logic [3:0]       row_addr,
  output logic             frame_done
);

  localparam int unsigned SHOW_MAX = BASE_TICKS << 3;
  localparam int unsigned TMR_W    = $clog2(SHOW_MAX + 1);
  localparam int unsigned CNT_MAX  = (CLK_DIV > DEAD_TICKS) ? CLK_DIV : DEAD_TICKS;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT_LO, SHIFT_HI, WAIT, BLANK, LATCH, POST
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       row, row_nx;
  logic [4:0]       col, col_nx;
  logic [1:0]       plane, plane_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic             frame_end;
  logic             blank_nx;
  logic             cap;
  logic [23:0]      data;
  logic [3:0]       fld;
  logic [5:0]       pix;

  function automatic logic [3:0] shade(input logic [3:0] f);
`ifdef LEDMATRIX_GAMMA_EN
    case (f)
      4'd0, 4'd1, 4'd2, 4'd3: shade = 4'd0;
      4'd4, 4'd5:             shade = 4'd1;
      4'd6:                   shade = 4'd2;
      4'd7:                   shade = 4'd3;
      4'd8:                   shade = 4'd4;
      4'd9:                   shade = 4'd5;
      4'd10:                  shade = 4'd6;
      4'd11:                  shade = 4'd8;
      4'd12:                  shade = 4'd9;
      4'd13:                  shade = 4'd11;
      4'd14:                  shade = 4'd13;
      default:                shade = 4'd15;
    endcase
`else
    shade = f;
`endif
  endfunction

  // Next-state logic: scan sequencing, phase counter and show timer.
  always_comb begin
    state_nx  = state;
    row_nx    = row;
    col_nx    = col;
    plane_nx  = plane;
    cnt_nx    = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    tmr_nx    = (tmr != '0) ? tmr - TMR_W'(1) : '0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = FETCH;
          row_nx   = '0;
          col_nx   = '0;
          plane_nx = '0;
        end
      end
      FETCH: begin
        state_nx = SHIFT_LO;
        cnt_nx   = DIV_LD;
      end
      SHIFT_LO: begin
        if (cnt == '0) begin
          state_nx = SHIFT_HI;
          cnt_nx   = DIV_LD;
        end
      end
      SHIFT_HI: begin
        if (cnt == '0) begin
          col_nx   = col + 5'd1;
          state_nx = (col == 5'd31) ? WAIT : FETCH;
        end
      end
      WAIT: begin
        if (tmr == '0) begin
          if (en) begin
            state_nx = BLANK;
            cnt_nx   = DEAD_LD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      BLANK: begin
        if (cnt == '0) state_nx = LATCH;
      end
      LATCH: begin
        state_nx = POST;
        cnt_nx   = DEAD_LD;
      end
      POST: begin
        if (cnt == '0) begin
          state_nx = FETCH;
          tmr_nx   = TMR_W'(BASE_TICKS << plane);
          plane_nx = plane + 2'd1;
          if (plane == 2'd3) begin
            row_nx = row + 4'd1;
            if (row == 4'd15) frame_end = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign blank_nx = state_nx inside {BLANK, LATCH, POST};
  assign cap      = (state == SHIFT_LO) && (cnt == DIV_LD);

  // Plane bit of each colour field, lowest field (R1) ends up in pix[0].
  always_comb begin
    data = fb.rd_data;
    fld  = '0;
    pix  = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      fld  = shade(data[3:0]);
      pix  = {fld[plane], pix[5:1]};
      data = data >> 4;
    end
  end

  // State and scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      plane <= '0;
      cnt   <= '0;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
      plane <= plane_nx;
      cnt   <= cnt_nx;
      tmr   <= tmr_nx;
    end
  end

  // Panel and RAM outputs, registered from the next-state decode so they change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb.rd_addr <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      row_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (state_nx == FETCH) fb.rd_addr <= {row_nx, col_nx};
      sclk       <= (state_nx == SHIFT_HI);
      lat        <= (state_nx == LATCH);
      if (state_nx == LATCH) row_addr <= ~row;
      frame_done <= frame_end;
      oe_n       <= !((tmr_nx != '0) && !blank_nx);
    end
  end

  // Colour bits captured on the first SHIFT_LO cycle, when rd_data for this pixel is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {b2, g2, r2, b1, g1, r1} <= '0;
    end else if (cap) begin
      {b2, g2, r2, b1, g1, r1} <= pix;
    end
  end

endmodule

// File: tb/tb_ledmatrix_scan.sv
// tb_ledmatrix_scan: directed bench for ledmatrix_scan with a protocol-level panel model.
`timescale 1ns/1ps
module tb_ledmatrix_scan;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned BASE_TICKS = 64;
  localparam int unsigned DEAD_TICKS = 4;
  localparam int PIX_PERIOD = 1 + 2 * CLK_DIV;
  localparam int NLIT = 13;
`ifdef LEDMATRIX_GAMMA_EN
  localparam logic [63:0] GAMMA_TAB = 64'hFDB9_8654_3211_0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic r1, g1, b1, r2, g2, b2, sclk, lat, oe_n, frame_done;
  logic [3:0] row_addr;
  logic [23:0] mem [512];

  ledmatrix_scan_if fb();

  ledmatrix_scan #(.CLK_DIV(CLK_DIV), .BASE_TICKS(BASE_TICKS), .DEAD_TICKS(DEAD_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fb(fb),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .sclk(sclk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous frame buffer: data one clock after the address.
  always @(posedge clk) fb.rd_data <= mem[fb.rd_addr];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th shifted pixel of the stream: 32 cols per plane, 4 planes per row, 16 rows per frame.
  function automatic int model_addr(input int kk);
    return ((kk / 128) % 16) * 32 + (kk % 32);
  endfunction

  function automatic logic [5:0] model_pix(input int kk);
    logic [23:0] w;
    logic [3:0]  lvl;
    logic [1:0]  pl;
    logic [5:0]  o;
`ifdef LEDMATRIX_GAMMA_EN
    logic [63:0] tmp;
`endif
    w  = mem[9'(model_addr(kk))];
    pl = 2'((kk / 32) % 4);
    o  = '0;
    for (int i = 0; i < 6; i++) begin
      lvl = w[3:0];
`ifdef LEDMATRIX_GAMMA_EN
      tmp = GAMMA_TAB >> {lvl, 2'b00};
      lvl = tmp[3:0];
`endif
      o = {o[4:0], lvl[pl]};
      w = w >> 4;
    end
    return o;
  endfunction

  int lit_k [NLIT] = '{4, 5, 37, 69, 101, 6, 70, 102, 136, 168, 200, 232, 2047};
`ifdef LEDMATRIX_GAMMA_EN
  logic [5:0] lit_v [NLIT] = '{6'b000000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                               6'b100000, 6'b000000, 6'b000000, 6'b000010, 6'b000000,
                               6'b000001, 6'b000000, 6'b111111};
`else
  logic [5:0] lit_v [NLIT] = '{6'b000000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                               6'b000000, 6'b100000, 6'b000000, 6'b001000, 6'b000100,
                               6'b000010, 6'b000001, 6'b111111};
`endif
  bit lit_hit [NLIT];

  int k, nlat, plane_rises, low_run, high_run, since_lat, since_rise, last_fd, frames;
  logic p_sclk, p_lat, p_oe, p_fd;
  bit model_clear = 1'b0;

  // Panel protocol checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n || model_clear) begin
      k = 0; nlat = 0; plane_rises = 0; low_run = 0; high_run = 0;
      since_lat = -1; since_rise = 0; last_fd = 0;
      if (!rst_n) frames = 0;
      p_sclk = 1'b0; p_lat = 1'b0; p_oe = 1'b1; p_fd = 1'b0;
    end else begin
      if (sclk && !p_sclk) begin
        if (plane_rises > 0) chk("pixel_period", since_rise, PIX_PERIOD);
        chk("rd_addr", int'(fb.rd_addr), model_addr(k));
        chk("colour", int'({r1, g1, b1, r2, g2, b2}), int'(model_pix(k)));
        for (int i = 0; i < NLIT; i++) begin
          if (lit_k[i] == k) begin
            chk("literal_colour", int'({r1, g1, b1, r2, g2, b2}), int'(lit_v[i]));
            lit_hit[i] = 1'b1;
          end
        end
        k++;
        plane_rises++;
        since_rise = 0;
      end
      since_rise++;

      if (lat) begin
        chk("lat_width", int'(p_lat), 0);
        if (!p_lat) begin
          chk("rises_per_latch", plane_rises, 32);
          chk("row_addr", int'(row_addr), 15 - ((nlat / 4) % 16));
          chk("blank_before_lat", int'(high_run >= int'(DEAD_TICKS)), 1);
          chk("oe_at_lat", int'(oe_n), 1);
          nlat++;
          plane_rises = 0;
          since_lat = 0;
        end
      end else if (since_lat >= 0) begin
        since_lat++;
        if (since_lat <= int'(DEAD_TICKS)) begin
          chk("post_dead", int'(oe_n), 1);
        end else begin
          chk("show_start", int'(oe_n), 0);
          since_lat = -1;
        end
      end

      if (!oe_n) begin
        low_run++;
      end else if (!p_oe) begin
        chk("show_len", low_run, int'(BASE_TICKS << ((nlat - 1) % 4)));
        low_run = 0;
      end
      high_run = oe_n ? high_run + 1 : 0;

      if (frame_done) begin
        chk("fd_width", int'(p_fd), 0);
        if (!p_fd) begin
          chk("fd_spacing", nlat - last_fd, 64);
          last_fd = nlat;
          frames++;
        end
      end

      p_sclk = sclk; p_lat = lat; p_oe = oe_n; p_fd = frame_done;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe_n"}, int'(oe_n), 1);
    chk({tag, "_sclk"}, int'(sclk), 0);
    chk({tag, "_lat"}, int'(lat), 0);
    chk({tag, "_rd_addr"}, int'(fb.rd_addr), 0);
    chk({tag, "_row_addr"}, int'(row_addr), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_colour"}, int'({r1, g1, b1, r2, g2, b2}), 0);
  endtask

  initial begin
    int n0, k0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[5]   = 24'h00000F;
    mem[6]   = 24'h000004;
    mem[40]  = 24'h842100;
    mem[511] = 24'hFFFFFF;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // One full frame plus the start of the next (covers rd_addr wrap 511 -> 0).
    for (int i = 0; i < 60000 && !(frames >= 1 && k >= 2088); i++) @(negedge clk);
    chk("frame_reached", int'(frames >= 1 && k >= 2088), 1);
    chk("frames_after_one", frames, 1);
    chk("lat_after_one", nlat, 65);

    // Drop enable mid-shift: the plane completes but is never latched.
    for (int i = 0; i < 50 && !sclk; i++) @(negedge clk);
    chk("en_drop_in_shift", int'(sclk), 1);
    en = 1'b0;
    n0 = nlat;
    repeat (1500) @(negedge clk);
    chk("en_off_no_latch", nlat, n0);
    chk("en_off_plane_done", plane_rises, 32);
    chk("en_off_oe", int'(oe_n), 1);
    k0 = k;
    repeat (50) @(negedge clk);
    chk("en_off_idle", k, k0);
    model_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_clear = 1'b0;
    en = 1'b1;

    // Reset during SHIFT_HI of row 3.
    for (int i = 0; i < 20000 && !(k >= 424 && sclk); i++) @(negedge clk);
    chk("reach_row3", int'(k >= 424 && sclk), 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2000 && k < 40; i++) @(negedge clk);
    chk("restart_progress", int'(k >= 40), 1);
    chk("restart_lat", nlat, 1);

    for (int i = 0; i < NLIT; i++) chk("literal_hit", int'(lit_hit[i]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
